// File: rtl/cavlc_pkg.sv
// CAVLC level coding: shared state type, constants and the suffixLength update rule.
package cavlc_pkg;

  localparam int ESC_PREFIX     = 15;
  localparam int ESC_SUFFIX_W   = 12;
  localparam int MAX_SUFFIX_LEN = 6;
  localparam int CODE_W         = 28;
  // Unsigned width of levelCode arithmetic; holds 2*|-4096|-1 without overflow.
  localparam int LC_W           = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_T1    = 2'd1,
    ST_LEVEL = 2'd2,
    ST_DRAIN = 2'd3
  } enc_state_e;

  // suffixLength adaptation after a non-trailing-one level. It is shared with
  // the decoder, so encoder and decoder cannot drift apart.
  function automatic logic [2:0] next_suffix_len(input logic [2:0]      suffix_len,
                                                 input logic [LC_W-1:0] level_mag);
    logic [2:0]      sl_v;
    logic [LC_W-1:0] thr_v;
    sl_v  = (suffix_len == 3'd0) ? 3'd1 : suffix_len;
    thr_v = 15'd3 << (sl_v - 3'd1);
    if ((level_mag > thr_v) && (sl_v < 3'(MAX_SUFFIX_LEN))) begin
      sl_v = sl_v + 3'd1;
    end else begin
      sl_v = sl_v;
    end
    return sl_v;
  endfunction

endpackage

// File: rtl/level_code_mapper.sv
// Combinational mapping of one signed level to its level_prefix/level_suffix codeword.
module level_code_mapper
  import cavlc_pkg::*;
#(
  parameter int LEVEL_W = 13
) (
  input  logic signed [LEVEL_W-1:0] level,
  input  logic        [2:0]         suffix_len,
  input  logic                      first_level,
  output logic        [CODE_W-1:0]  code_word,
  output logic        [4:0]         code_len,
  output logic                      err,
  output logic        [LC_W-1:0]    level_mag
);

  logic [LC_W-1:0]         level_ext_s;
  logic [LC_W-1:0]         level_code_s;
  logic [LC_W-1:0]         esc_base_s;
  logic [LC_W-1:0]         esc_raw_s;
  logic [4:0]              prefix_s;
  logic [4:0]              suf_len_s;
  logic [ESC_SUFFIX_W-1:0] suffix_s;
  logic                    escape_s;
  logic                    zero_s;

  // Magnitude and levelCode. A zero level is illegal and maps to levelCode 0.
  // The first-level adjustment is applied only when it cannot go negative
  // (a +/-1 there means the block is malformed; it is coded unadjusted).
  always_comb begin
    level_ext_s = {{(LC_W-LEVEL_W){level[LEVEL_W-1]}}, level};
    zero_s      = (level_ext_s == {LC_W{1'b0}});
    if (level[LEVEL_W-1]) begin
      level_mag = {LC_W{1'b0}} - level_ext_s;
    end else begin
      level_mag = level_ext_s;
    end
    if (zero_s) begin
      level_code_s = 15'd0;
    end else if (level[LEVEL_W-1]) begin
      level_code_s = (level_mag << 1) - 15'd1;
    end else begin
      level_code_s = (level_mag << 1) - 15'd2;
    end
    if (first_level && (level_code_s >= 15'd2)) begin
      level_code_s = level_code_s - 15'd2;
    end else begin
      level_code_s = level_code_s;
    end
  end

  // Prefix/suffix split, escape handling with suffix saturation, codeword assembly.
  always_comb begin
    esc_base_s = 15'd15 << suffix_len;
    escape_s   = 1'b0;
    esc_raw_s  = 15'd0;
    prefix_s   = 5'd0;
    suf_len_s  = 5'd0;
    suffix_s   = 12'd0;
    if (suffix_len == 3'd0) begin
      if (level_code_s < 15'd14) begin
        prefix_s = 5'(level_code_s);
      end else if (level_code_s < 15'd30) begin
        prefix_s  = 5'd14;
        suf_len_s = 5'd4;
        suffix_s  = 12'(level_code_s - 15'd14);
      end else begin
        escape_s  = 1'b1;
        esc_raw_s = level_code_s - 15'd30;
      end
    end else begin
      if (level_code_s < esc_base_s) begin
        prefix_s  = 5'(level_code_s >> suffix_len);
        suf_len_s = {2'd0, suffix_len};
        suffix_s  = 12'(level_code_s & ((15'd1 << suffix_len) - 15'd1));
      end else begin
        escape_s  = 1'b1;
        esc_raw_s = level_code_s - esc_base_s;
      end
    end
    if (escape_s) begin
      prefix_s  = 5'(ESC_PREFIX);
      suf_len_s = 5'(ESC_SUFFIX_W);
      if (esc_raw_s > 15'd4095) begin
        suffix_s = 12'hFFF;
      end else begin
        suffix_s = 12'(esc_raw_s);
      end
    end else begin
      suffix_s = suffix_s;
    end
    err       = zero_s || (escape_s && (esc_raw_s > 15'd4095));
    code_word = ({{(CODE_W-1){1'b0}}, 1'b1} << suf_len_s)
              | {{(CODE_W-ESC_SUFFIX_W){1'b0}}, suffix_s};
    code_len  = prefix_s + 5'd1 + suf_len_s;
  end

endmodule

// File: rtl/level_encoding_unit.sv
// CAVLC level encoder: block FSM, suffixLength tracking and single-entry codeword register.
module level_encoding_unit
  import cavlc_pkg::*;
#(
  parameter int LEVEL_W = 13
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic                      BlockStart,
  input  logic        [4:0]         TotalCoeff,
  input  logic        [1:0]         TrailingOnes,
  output logic                      Busy,
  input  logic signed [LEVEL_W-1:0] LevelIn,
  input  logic                      LevelValid,
  output logic                      LevelReady,
  output logic        [CODE_W-1:0]  CodeWord,
  output logic        [4:0]         CodeLen,
  output logic                      CodeValid,
  input  logic                      CodeReady,
  output logic                      BlockDone,
  output logic                      LevelErr
);

  enc_state_e        state_r;
  logic              busy_r;
  logic [4:0]        cnt_r;
  logic [1:0]        t1_left_r;
  logic [2:0]        sl_r;
  logic              first_r;
  logic              adj_r;
  logic [CODE_W-1:0] code_word_r;
  logic [4:0]        code_len_r;
  logic              code_valid_r;
  logic              done_r;
  logic              err_r;

  logic [CODE_W-1:0] map_word_s;
  logic [4:0]        map_len_s;
  logic              map_err_s;
  logic [LC_W-1:0]   map_mag_s;
  logic [CODE_W-1:0] next_word_s;
  logic [4:0]        next_len_s;
  logic              next_err_s;
  logic              level_ready_s;
  logic              lvl_hs_s;
  logic              code_hs_s;

  level_code_mapper #(.LEVEL_W(LEVEL_W)) u_mapper (
    .level       (LevelIn),
    .suffix_len  (sl_r),
    .first_level (first_r && adj_r),
    .code_word   (map_word_s),
    .code_len    (map_len_s),
    .err         (map_err_s),
    .level_mag   (map_mag_s)
  );

  assign level_ready_s = ((state_r == ST_T1) || (state_r == ST_LEVEL))
                       && (!code_valid_r || CodeReady);
  assign lvl_hs_s      = LevelValid && level_ready_s;
  assign code_hs_s     = code_valid_r && CodeReady;

  // Select the trailing-one sign bit or the prefix/suffix codeword for the current level.
  always_comb begin
    if (state_r == ST_T1) begin
      next_word_s = {{(CODE_W-1){1'b0}}, LevelIn[LEVEL_W-1]};
      next_len_s  = 5'd1;
      next_err_s  = (map_mag_s != 15'd1);
    end else begin
      next_word_s = map_word_s;
      next_len_s  = map_len_s;
      next_err_s  = map_err_s;
    end
  end

  // Block FSM, remaining-level counters and suffixLength adaptation.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      cnt_r     <= 5'd0;
      t1_left_r <= 2'd0;
      sl_r      <= 3'd0;
      first_r   <= 1'b0;
      adj_r     <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (BlockStart) begin
            cnt_r     <= TotalCoeff;
            t1_left_r <= TrailingOnes;
            sl_r      <= ((TotalCoeff > 5'd10) && (TrailingOnes < 2'd3)) ? 3'd1 : 3'd0;
            adj_r     <= (TrailingOnes < 2'd3);
            first_r   <= 1'b1;
            if (TotalCoeff == 5'd0) begin
              done_r <= 1'b1;
            end else if (TrailingOnes != 2'd0) begin
              state_r <= ST_T1;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_LEVEL;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_T1: begin
          if (lvl_hs_s) begin
            cnt_r     <= cnt_r - 5'd1;
            t1_left_r <= t1_left_r - 2'd1;
            if (cnt_r == 5'd1) begin
              state_r <= ST_DRAIN;
            end else if (t1_left_r == 2'd1) begin
              state_r <= ST_LEVEL;
            end
          end
        end
        ST_LEVEL: begin
          if (lvl_hs_s) begin
            cnt_r   <= cnt_r - 5'd1;
            first_r <= 1'b0;
            sl_r    <= next_suffix_len(sl_r, map_mag_s);
            if (cnt_r == 5'd1) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (code_hs_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry codeword register; the error pulse is aligned with its codeword.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      code_word_r  <= {CODE_W{1'b0}};
      code_len_r   <= 5'd0;
      code_valid_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      err_r <= lvl_hs_s && next_err_s;
      if (lvl_hs_s) begin
        code_word_r  <= next_word_s;
        code_len_r   <= next_len_s;
        code_valid_r <= 1'b1;
      end else if (code_hs_s) begin
        code_valid_r <= 1'b0;
      end
    end
  end

  assign Busy       = busy_r;
  assign LevelReady = level_ready_s;
  assign CodeWord   = code_word_r;
  assign CodeLen    = code_len_r;
  assign CodeValid  = code_valid_r;
  assign BlockDone  = done_r;
  assign LevelErr   = err_r;

endmodule

// File: doc/level_encoding_unit.md
Name: level_encoding_unit

Overview:
- CAVLC level encoder for the transmit path; performs the inverse of the level decode used in the receive path.
- Consumes the signed coefficient levels of one 4x4 block in reverse scan order and emits one variable-length codeword per level, right-aligned: either a trailing-one sign bit or a level_prefix plus level_suffix.
- Tracks suffixLength adaptation and the first-non-trailing-one adjustment across the block.
- Sits between the coefficient scan/count stage and the bitstream packer.

Parameters:
- LEVEL_W, 13, signed level width; matches decoder LevelOut width.
- MAX_SUFFIX_LEN, 6, upper bound of suffixLength.
- ESC_SUFFIX_W, 12, escape suffix width (prefix 15).

Ports:
- Clk  in  1  clock
- nReset  in  1  asynchronous active-low reset
- BlockStart  in  1  one-cycle strobe; samples TotalCoeff and TrailingOnes; accepted only in IDLE
- TotalCoeff  in  5  non-zero coefficient count, 0..16
- TrailingOnes  in  2  trailing-ones count, 0..3, and not greater than TotalCoeff
- Busy  out  1  high from accepted BlockStart until BlockDone
- LevelIn  in  LEVEL_W  signed level, two's complement
- LevelValid  in  1  LevelIn valid
- LevelReady  out  1  level accepted when LevelValid && LevelReady
- CodeWord  out  28  codeword bits, right-aligned, MSB sent first
- CodeLen  out  5  codeword length, 1..28
- CodeValid  out  1  codeword valid
- CodeReady  in  1  downstream accepts when CodeValid && CodeReady
- BlockDone  out  1  one-cycle pulse after the last codeword handshake, or the cycle after BlockStart when TotalCoeff==0
- LevelErr  out  1  one-cycle pulse on an illegal or unencodable level

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; suffixLength=0; counters=0.
- Assertion of nReset mid-block aborts the block; any pending codeword is dropped.
- FSM states: IDLE, T1, LEVEL, DRAIN.
  - IDLE->T1 on BlockStart if TrailingOnes>0.
  - IDLE->LEVEL if TrailingOnes==0 and TotalCoeff>0.
  - IDLE with TotalCoeff==0: stay in IDLE, pulse BlockDone next cycle.
  - BlockStart outside IDLE is ignored.
- Initial suffixLength = 1 if TotalCoeff>10 and TrailingOnes<3, else 0.
- Counter of remaining levels loaded with TotalCoeff; decremented on each level handshake.
- Output register: single entry. LevelReady = !CodeValid || CodeReady, and gated off in IDLE/DRAIN. Latency is one cycle from level handshake to CodeValid. Full throughput is one level per cycle with CodeReady held high.
- T1 state, for the first TrailingOnes levels:
  - CodeLen=1; CodeWord[0] = 1 if the level is negative, else 0.
  - LevelErr if |level| != 1; codeword is still emitted.
- LEVEL state:
  - levelCode = 2*L-2 if L>0, else -2*L-1.
  - On the first LEVEL-state level only, subtract 2 if TrailingOnes<3.
  - suffixLength==0:
    - levelCode<14: prefix=levelCode, suffix length 0.
    - levelCode<30: prefix=14, suffix=levelCode-14, suffix length 4.
    - otherwise: prefix=15, suffix=levelCode-30, suffix length 12.
  - suffixLength>0:
    - levelCode < (15<<sL): prefix=levelCode>>sL, suffix=levelCode[sL-1:0], suffix length sL.
    - otherwise: prefix=15, suffix=levelCode-(15<<sL), suffix length 12.
  - Codeword = prefix zeros, then a 1, then the suffix. CodeWord = (1<<sufLen)|suffix; CodeLen = prefix+1+sufLen.
  - L==0, or escape suffix > 4095: LevelErr pulse; suffix saturates to 4095; codeword is emitted.
  - After each level, update suffixLength in this order:
    - if sL==0, sL=1;
    - then if |L| > (3<<(sL-1)) and sL<MAX_SUFFIX_LEN, sL++.
- Leave T1 for LEVEL, or for DRAIN if no levels remain. LEVEL->DRAIN when the count reaches 0.
- DRAIN: wait for the final codeword handshake, pulse BlockDone, go to IDLE. A simultaneous BlockStart in that cycle is ignored.
- Intermediate arithmetic is 15 bits unsigned so that |-4096| does not overflow.

Decomposition:
- Shared package cavlc_pkg holds:
  - FSM state enum;
  - constants ESC_PREFIX=15, ESC_SUFFIX_W=12, MAX_SUFFIX_LEN=6, CODE_W=28;
  - the suffixLength-update function, shared with the decoder.
- One natural sub-module: level_code_mapper, a combinational block taking level, sL and the first-level flag and producing CodeWord, CodeLen and err. The FSM, counters and output register stay in the top module.

Test Plan:
- Block TotalCoeff=3, TrailingOnes=1, levels -1,3,-2 with CodeReady=1 -> codewords (1,len1), (0b001,len3), (0b011,len3); BlockDone one cycle after the third handshake.
- TotalCoeff=1, TrailingOnes=0, level 20 -> escape: CodeWord=0x1006, CodeLen=28; internal sL ends at 2.
- TotalCoeff=11, TrailingOnes=0 -> initial sL=1. First level +1 gives levelCode 0 -> CodeWord=0b10, CodeLen=2.
- Back-pressure: hold CodeReady=0 for 5 cycles mid-block -> LevelReady low, CodeWord stable, no level lost or duplicated.
- Error cases:
  - T1 level of +2 -> LevelErr pulse; codeword (0,len1) still emitted.
  - Level 0 in LEVEL state -> LevelErr pulse.
- Control cases:
  - TotalCoeff=0 -> BlockDone the next cycle with no codeword.
  - nReset asserted mid-block -> all outputs 0 and FSM in IDLE.
  - New block after reset encodes correctly.
